pccard_host_ctrl: RTL and testbench
===================================

PCCARD_HOST_CTRL -- requirements
Module: pccard_host_ctrl

Interface
REQ-001 SHALL have parameters SETUP_CYC (default 1), the address/CE setup cycles before a strobe.
REQ-002 SHALL have STROBE_CYC (default 2), the strobe-active cycles.
REQ-003 SHALL have HOLD_CYC (default 1), the address/CE/data hold cycles after a strobe; all three SHALL be legal from 1 to 15.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  host request, held until ack.
- space  in  2  00 common, 01 attribute, 10 I/O, 11 reserved.
- rw  in  1  1 read, 0 write.
- word  in  1  1 16-bit, 0 8-bit.
- haddr  in  26  byte address.
- wdata  in  16  write data; byte writes use wdata[7:0].
- rdata  out  16  read data; byte reads return the byte on [7:0], [15:8]=0.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = request rejected, no card cycle.
- irq_en  in  1  interrupt enable.
- irq  out  1  synchronized card interrupt.
- addr  out  26  card address.
- data_out  out  16  data driven to card.
- data_in  in  16  data from card.
- cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2  out  1 each  card strobes, all active-high.
- cc_ireq  in  1  card interrupt request, asynchronous.

Function
REQ-005 SHALL implement FSM IDLE, SETUP, STROBE, HOLD, DONE, with one shared cycle counter.
REQ-006 IDLE with req=1 SHALL go to SETUP on the next edge, or to DONE with err=1 when space=11 or (word=1 and haddr[0]=1).
REQ-007 On acceptance, SHALL register addr, cc_ce1, cc_ce2, cc_reg and data_out; these SHALL stay stable through SETUP, STROBE and HOLD.
REQ-008 Word access SHALL drive ce1=1, ce2=1, addr[0]=0.
REQ-009 Byte access SHALL drive ce1=1, ce2=0, addr[0]=haddr[0].
REQ-010 cc_reg SHALL be 1 for attribute and I/O space and 0 for common space.
REQ-011 In STROBE, SHALL assert exactly one strobe: cc_oe for memory read, cc_we for memory write, cc_iord for I/O read, cc_iowr for I/O write.
REQ-012 Write data_out SHALL be wdata, or {8'h00, wdata[7:0]} for byte writes; reads SHALL drive data_out=0.
REQ-013 SETUP SHALL last SETUP_CYC cycles, STROBE STROBE_CYC cycles and HOLD HOLD_CYC cycles, then the FSM SHALL enter DONE.
REQ-014 For reads, rdata SHALL be captured from data_in on the edge ending the last STROBE cycle, and held until the next read capture.
REQ-015 DONE SHALL last one cycle with ack=1, then go to IDLE; ce1, ce2, reg and strobes SHALL be 0 in DONE and IDLE.
REQ-016 With acceptance edge at cycle C, ack SHALL be high in cycle C+SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (C+5 at defaults).
REQ-017 The minimum gap between ack and the next acceptance SHALL be one IDLE cycle; req changes outside IDLE SHALL be ignored.
REQ-018 Two strobes SHALL never be high in the same cycle, and no strobe SHALL be high outside STROBE.
REQ-019 cc_ireq SHALL pass through a two-flop synchronizer, with irq = synchronized value AND irq_en, registered.

Reset
REQ-020 Reset SHALL force IDLE, clear the counter and set ack, err, irq, rdata, addr, data_out and all cc_* outputs to 0 on the next edge.
REQ-021 Reset asserted mid-cycle SHALL drop all strobes within one clock and SHALL NOT produce ack for the aborted request.

Verification
REQ-022 Attribute byte read, haddr=0x1000, data_in=0x0001, defaults: cc_reg=1, ce1=1, ce2=0; cc_oe high for exactly cycles C+2..C+3; ack at C+5; rdata=0x0001.
REQ-023 I/O word write, haddr=0x0008, wdata=0xBEEF: cc_reg=1, ce1=ce2=1, addr=0x0008; cc_iowr high 2 cycles; data_out=0xBEEF from C+1 to C+4; err=0.
REQ-024 I/O odd byte read, haddr=0x0003, data_in=0x1234: addr[0]=1, ce2=0, cc_iord pulse, rdata=0x0034.
REQ-025 Word request with haddr=0x0001, then space=11: each gives ack with err=1 at C+1 and no strobe ever asserted.
REQ-026 Reset raised during STROBE of a common write: cc_we=0 next cycle, no ack; the next request completes normally.
REQ-027 cc_ireq=1 with irq_en=1: irq=1 after 3 edges; irq_en=0 gives irq=0 on the next edge.

Source files
------------

// File: rtl/pccard_host_ctrl.sv
// PC Card host-side cycle controller: turns a held host request into a timed
// setup/strobe/hold card cycle, plus a synchronized, gated card interrupt.
module pccard_host_ctrl #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  space,
    input  logic        rw,
    input  logic        word,
    input  logic [25:0] haddr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    input  logic        irq_en,
    output logic        irq,
    output logic [25:0] addr,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        cc_reg,
    output logic        cc_oe,
    output logic        cc_we,
    output logic        cc_iord,
    output logic        cc_iowr,
    output logic        cc_ce1,
    output logic        cc_ce2,
    input  logic        cc_ireq
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rd;
    logic        r_io;
    logic        r_word;
    logic [15:0] r_rdata;
    logic        r_ack;
    logic        r_err;
    logic [25:0] r_addr;
    logic [15:0] r_data_out;
    logic        r_reg;
    logic        r_oe;
    logic        r_we;
    logic        r_iord;
    logic        r_iowr;
    logic        r_ce1;
    logic        r_ce2;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_irq;

    logic        w_reject;

    assign w_reject = (space == 2'b11) || (word && haddr[0]);

    // Card cycle sequencer; strobes are set/cleared on the edges entering/leaving STROBE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_rd       <= 1'b0;
            r_io       <= 1'b0;
            r_word     <= 1'b0;
            r_rdata    <= 16'h0000;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 26'd0;
            r_data_out <= 16'h0000;
            r_reg      <= 1'b0;
            r_oe       <= 1'b0;
            r_we       <= 1'b0;
            r_iord     <= 1'b0;
            r_iowr     <= 1'b0;
            r_ce1      <= 1'b0;
            r_ce2      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (req) begin
                        if (w_reject) begin
                            r_state <= DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state    <= SETUP;
                            r_cnt      <= SETUP_LAST;
                            r_addr     <= word ? {haddr[25:1], 1'b0} : haddr;
                            r_ce1      <= 1'b1;
                            r_ce2      <= word;
                            r_reg      <= (space != 2'b00);
                            r_data_out <= rw ? 16'h0000 : (word ? wdata : {8'h00, wdata[7:0]});
                            r_rd       <= rw;
                            r_io       <= (space == 2'b10);
                            r_word     <= word;
                        end
                    end
                end
                SETUP: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= STROBE;
                        r_cnt   <= STROBE_LAST;
                        r_oe    <= r_rd & ~r_io;
                        r_we    <= ~r_rd & ~r_io;
                        r_iord  <= r_rd & r_io;
                        r_iowr  <= ~r_rd & r_io;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= HOLD;
                        r_cnt   <= HOLD_LAST;
                        r_oe    <= 1'b0;
                        r_we    <= 1'b0;
                        r_iord  <= 1'b0;
                        r_iowr  <= 1'b0;
                        if (r_rd) begin
                            r_rdata <= r_word ? data_in : {8'h00, data_in[7:0]};
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= DONE;
                        r_ack      <= 1'b1;
                        r_err      <= 1'b0;
                        r_ce1      <= 1'b0;
                        r_ce2      <= 1'b0;
                        r_reg      <= 1'b0;
                        r_data_out <= 16'h0000;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_oe    <= 1'b0;
                    r_we    <= 1'b0;
                    r_iord  <= 1'b0;
                    r_iowr  <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous card interrupt, then enable gate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_sync1 <= cc_ireq;
            r_sync2 <= r_sync1;
            r_irq   <= r_sync2 & irq_en;
        end
    end

    assign rdata    = r_rdata;
    assign ack      = r_ack;
    assign err      = r_err;
    assign irq      = r_irq;
    assign addr     = r_addr;
    assign data_out = r_data_out;
    assign cc_reg   = r_reg;
    assign cc_oe    = r_oe;
    assign cc_we    = r_we;
    assign cc_iord  = r_iord;
    assign cc_iowr  = r_iowr;
    assign cc_ce1   = r_ce1;
    assign cc_ce2   = r_ce2;

endmodule

// File: tb/tb_pccard_host_ctrl.sv
// Self-checking bench for pccard_host_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-numbered reference model.
module tb_pccard_host_ctrl;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  space;
    logic        rw;
    logic        word;
    logic [25:0] haddr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        err;
    logic        irq_en;
    logic        irq;
    logic [25:0] addr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2;
    logic        cc_ireq;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_rdata = 16'h0000;

    pccard_host_ctrl #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
        .clk(clk), .reset(reset), .req(req), .space(space), .rw(rw), .word(word),
        .haddr(haddr), .wdata(wdata), .rdata(rdata), .ack(ack), .err(err),
        .irq_en(irq_en), .irq(irq), .addr(addr), .data_out(data_out),
        .data_in(data_in), .cc_reg(cc_reg), .cc_oe(cc_oe), .cc_we(cc_we),
        .cc_iord(cc_iord), .cc_iowr(cc_iowr), .cc_ce1(cc_ce1), .cc_ce2(cc_ce2),
        .cc_ireq(cc_ireq)
    );

    always #5 clk = ~clk;

    // One transaction; cycle n is the clock period following the n-th edge after req is driven.
    task automatic run_txn(input logic [1:0] sp, input logic r, input logic w,
                           input logic [25:0] ha, input logic [15:0] wd,
                           input logic [15:0] din, input string name);
        logic        bad;
        logic [25:0] e_addr;
        logic [15:0] e_do;
        logic [3:0]  e_str;
        logic [8:0]  e_ctl, a_ctl;
        int          total;
        bad    = (sp == 2'b11) || (w && ha[0]);
        e_addr = w ? (ha & ~26'd1) : ha;
        e_do   = r ? 16'h0000 : (w ? wd : (wd & 16'h00FF));
        if (sp == 2'b10) e_str = r ? 4'b0010 : 4'b0001;
        else             e_str = r ? 4'b1000 : 4'b0100;
        total  = bad ? 1 : S + T + H + 1;
        @(negedge clk);
        space = sp; rw = r; word = w; haddr = ha; wdata = wd; data_in = din; req = 1'b1;
        for (int n = 1; n <= total; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                req = 1'b0; haddr = 26'($urandom); wdata = 16'($urandom);
                space = 2'($urandom); rw = 1'($urandom); word = 1'($urandom);
            end
            a_ctl = {ack, err, cc_reg, cc_ce1, cc_ce2, cc_oe, cc_we, cc_iord, cc_iowr};
            if (bad)            e_ctl = 9'b1_1000_0000;
            else if (n < total) e_ctl = {2'b00, (sp != 2'b00), 1'b1, w,
                                         ((n > S) && (n <= S + T)) ? e_str : 4'b0000};
            else                e_ctl = 9'b1_0000_0000;
            checks++;
            if (a_ctl !== e_ctl) begin
                failures++;
                $display("FAIL %s ctl cycle %0d: got %b want %b", name, n, a_ctl, e_ctl);
            end
            if (!bad && n < total) begin
                checks++;
                if ({addr, data_out} !== {e_addr, e_do}) begin
                    failures++;
                    $display("FAIL %s addr/data cycle %0d: got %h/%h want %h/%h",
                             name, n, addr, data_out, e_addr, e_do);
                end
            end
        end
        if (!bad && r) exp_rdata = w ? din : (din & 16'h00FF);
        checks++;
        if (rdata !== exp_rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack, err} !== 2'b00) begin
            failures++;
            $display("FAIL %s ack after done: got %b want 00", name, {ack, err});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack, err, irq, rdata, addr, data_out, cc_reg, cc_oe, cc_we, cc_iord,
             cc_iowr, cc_ce1, cc_ce2} !== 68'd0) begin
            failures++;
            $display("FAIL reset outputs: got ack=%b addr=%h do=%h rdata=%h want all zero",
                     ack, addr, data_out, rdata);
        end
        exp_rdata = 16'h0000;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_txn(2'b01, 1'b1, 1'b0, 26'h0001000, 16'h0000, 16'h0001, "attr_byte_read");
        run_txn(2'b10, 1'b0, 1'b1, 26'h0000008, 16'hBEEF, 16'h5555, "io_word_write");
        run_txn(2'b10, 1'b1, 1'b0, 26'h0000003, 16'h0000, 16'h1234, "io_odd_byte_read");
        run_txn(2'b00, 1'b1, 1'b1, 26'h3FFFFFE, 16'h0000, 16'hA5C3, "common_word_read");
    endtask

    task automatic test_errors();
        run_txn(2'b00, 1'b1, 1'b1, 26'h0000001, 16'h1111, 16'h2222, "err_odd_word");
        run_txn(2'b11, 1'b0, 1'b0, 26'h0000010, 16'h3333, 16'h4444, "err_reserved");
    endtask

    task automatic test_reset_mid_strobe();
        @(negedge clk);
        space = 2'b00; rw = 1'b0; word = 1'b1; haddr = 26'h0000020; wdata = 16'hCAFE; req = 1'b1;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (cc_we !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset we in strobe: got %b want 1", cc_we);
        end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({cc_we, cc_oe, cc_iord, cc_iowr, cc_ce1, cc_ce2, cc_reg, ack, addr, data_out} !== 50'd0) begin
            failures++;
            $display("FAIL mid_reset outputs: got we=%b ce1=%b ack=%b addr=%h want zero",
                     cc_we, cc_ce1, ack, addr);
        end
        exp_rdata = 16'h0000;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset stray ack cycle %0d: got %b want 0", i, ack);
            end
        end
        run_txn(2'b00, 1'b0, 1'b1, 26'h0000040, 16'h1357, 16'h0000, "after_reset_write");
    endtask

    task automatic test_irq();
        @(negedge clk);
        irq_en = 1'b1; cc_ireq = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (irq !== (e == 3)) begin
                failures++;
                $display("FAIL irq latency edge %0d: got %b want %b", e, irq, (e == 3));
            end
        end
        irq_en = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq gate: got %b want 0", irq);
        end
        cc_ireq = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  sp;
        logic        r, w;
        logic [25:0] ha;
        for (int i = 0; i < 40; i++) begin
            sp = 2'($urandom);
            r  = 1'($urandom);
            w  = 1'($urandom);
            ha = 26'($urandom);
            if ($urandom_range(3, 0) != 0 && w) ha[0] = 1'b0;
            run_txn(sp, r, w, ha, 16'($urandom), 16'($urandom), "random");
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; space = 2'b00; rw = 1'b0; word = 1'b0;
        haddr = 26'd0; wdata = 16'h0000; data_in = 16'h0000; irq_en = 1'b0; cc_ireq = 1'b0;
        test_reset();
        test_directed();
        test_errors();
        test_reset_mid_strobe();
        test_irq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
